// File: rtl/sdram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sdram_arbiter
//  Description : Three-master request arbiter in front of the single-port
//                SDRAM controller. Port 0 (video) has fixed priority bounded
//                by a hog limit; ports 1 (CPU) and 2 (DMA/USB) share the
//                remaining slots round-robin. One transaction in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int MAX_HOG = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]     req_wdata,
  input  logic [3*(DATA_W/8)-1:0] req_wen,
  output logic [2:0]              req_ready,
  output logic [DATA_W-1:0]       req_rdata,
  output logic                    m_valid,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wen,
  input  logic                    m_ready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic                    m_rdata_valid,
  output logic [1:0]              cur_id
);

  localparam int STRB_W = DATA_W / 8;
  localparam int HOG_W  = (MAX_HOG > 0) ? $clog2(MAX_HOG + 1) : 1;
  localparam logic [HOG_W-1:0] HOG_LIMIT = HOG_W'(MAX_HOG);
  localparam logic [1:0] ID_NONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wen_q, m_wen_d;
  logic [2:0]          req_ready_q, req_ready_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic [1:0]          cur_id_q, cur_id_d;
  logic                rr_q, rr_d;
  logic [HOG_W-1:0]    hog_cnt_q, hog_cnt_d;

  logic                others_valid;
  logic                port0_masked;
  logic                grant_any;
  logic [1:0]          grant_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wen;

  // Pick the winner among the asserted requests; only consumed in IDLE.
  always_comb begin
    others_valid = req_valid[1] | req_valid[2];
    // Port 0 is set aside for one decision once it has used up its hog budget.
    port0_masked = (hog_cnt_q == HOG_LIMIT) && others_valid;
    grant_any    = 1'b1;
    grant_id     = ID_NONE;
    if (req_valid[0] && !port0_masked) begin
      grant_id = 2'd0;
    end else if (req_valid[1] && req_valid[2]) begin
      grant_id = rr_q ? 2'd2 : 2'd1;
    end else if (req_valid[1]) begin
      grant_id = 2'd1;
    end else if (req_valid[2]) begin
      grant_id = 2'd2;
    end else begin
      grant_any = 1'b0;
    end
  end

  // Route the winning port's payload to the latch inputs.
  always_comb begin
    sel_addr  = req_addr[0 +: ADDR_W];
    sel_wdata = req_wdata[0 +: DATA_W];
    sel_wen   = req_wen[0 +: STRB_W];
    case (grant_id)
      2'd1: begin
        sel_addr  = req_addr[ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[DATA_W +: DATA_W];
        sel_wen   = req_wen[STRB_W +: STRB_W];
      end
      2'd2: begin
        sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[2*DATA_W +: DATA_W];
        sel_wen   = req_wen[2*STRB_W +: STRB_W];
      end
      default: ;
    endcase
  end

  // Transaction sequencer: next state, payload latch and completion pulse.
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wen_d     = m_wen_q;
    req_ready_d = 3'b000;
    req_rdata_d = req_rdata_q;
    cur_id_d    = cur_id_q;
    rr_d        = rr_q;
    hog_cnt_d   = hog_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          m_addr_d  = sel_addr;
          m_wdata_d = sel_wdata;
          m_wen_d   = sel_wen;
          m_valid_d = 1'b1;
          cur_id_d  = grant_id;
          state_d   = S_ISSUE;
          if (grant_id == 2'd0) begin
            // Only count port-0 wins that actually made someone else wait.
            if (!others_valid) begin
              hog_cnt_d = '0;
            end else if (hog_cnt_q != HOG_LIMIT) begin
              hog_cnt_d = hog_cnt_q + HOG_W'(1);
            end
          end else begin
            hog_cnt_d = '0;
            rr_d      = (grant_id == 2'd1);
          end
        end
      end

      S_ISSUE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_wen_q != '0) begin
            req_ready_d = 3'b001 << cur_id_q;
            state_d     = S_DONE;
          end else begin
            state_d = S_WAIT_RD;
          end
        end
      end

      S_WAIT_RD: begin
        if (m_rdata_valid) begin
          req_rdata_d = m_rdata;
          req_ready_d = 3'b001 << cur_id_q;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        // The completion pulse is already on the outputs this cycle.
        cur_id_d = ID_NONE;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      m_valid_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wen_q     <= '0;
      req_ready_q <= 3'b000;
      req_rdata_q <= '0;
      cur_id_q    <= ID_NONE;
      rr_q        <= 1'b0;
      hog_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wen_q     <= m_wen_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
      cur_id_q    <= cur_id_d;
      rr_q        <= rr_d;
      hog_cnt_q   <= hog_cnt_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wen     = m_wen_q;
  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
  assign cur_id    = cur_id_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sdram_arbiter
//  Description : Self-checking bench for sdram_arbiter with a behavioural
//                SDRAM controller, a grant/completion scoreboard, a table of
//                single transactions and hand-written arbitration sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  req_valid;
  logic [71:0] req_addr;
  logic [95:0] req_wdata;
  logic [11:0] req_wen;
  logic [2:0]  req_ready;
  logic [31:0] req_rdata;
  logic        m_valid;
  logic [23:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wen;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_rdata_valid;
  logic [1:0]  cur_id;

  sdram_arbiter #(.ADDR_W(24), .DATA_W(32), .MAX_HOG(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wen(req_wen), .req_ready(req_ready), .req_rdata(req_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
    .cur_id(cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
  } grant_t;

  typedef struct packed {
    logic [1:0]  id;
    logic        is_rd;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    int          port;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    int          stall;
    int          lat;
    logic [31:0] ret;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  grant_t exp_grant[$];
  done_t  exp_done[$];

  // Controller model knobs, set by the stimulus before each transaction.
  int          ctrl_stall = 0;
  int          ctrl_lat   = 1;
  logic [31:0] ctrl_rdata = 32'h0;

  int          last_grant_cyc = 0;
  int          last_ready_cyc = 0;
  int          last_rdv_cyc   = -10;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Behavioural controller: stalls m_ready, returns read data after a latency.
  initial begin : ctrl
    int   stall_cnt;
    int   rd_cnt;
    logic p_mv, p_mr, p_rstn, p_rd;
    stall_cnt = 0; rd_cnt = 0;
    p_mv = 1'b0; p_mr = 1'b0; p_rstn = 1'b0; p_rd = 1'b0;
    m_ready = 1'b1; m_rdata_valid = 1'b0; m_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      m_rdata_valid = 1'b0;
      m_rdata       = 32'hBAAD_F00D;
      if (p_mv && p_mr && p_rstn && p_rd) rd_cnt = ctrl_lat;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          m_rdata_valid = 1'b1;
          m_rdata       = ctrl_rdata;
        end
      end
      if (m_valid && !p_mv) stall_cnt = ctrl_stall;
      if (m_valid) begin
        if (stall_cnt == 0) m_ready = 1'b1;
        else begin
          m_ready = 1'b0;
          stall_cnt--;
        end
      end else begin
        m_ready = 1'b1;   // readiness while nothing is offered must be ignored
      end
      p_mv = m_valid; p_mr = m_ready; p_rstn = rstn; p_rd = (m_wen == 4'h0);
    end
  end

  // Monitor: scoreboard grants and completions, check payload stability.
  logic        mon_mv = 1'b0;
  logic        mon_mr = 1'b0;
  logic [23:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_wen;
  grant_t      g;
  done_t       d;

  always @(negedge clk) begin
    if (m_rdata_valid) last_rdv_cyc = cyc;
    if (rstn) begin
      if (m_valid && !mon_mv) begin
        last_grant_cyc = cyc;
        hold_addr = m_addr; hold_wdata = m_wdata; hold_wen = m_wen;
        if (exp_grant.size() == 0) fail_now("unexpected_grant");
        else begin
          g = exp_grant.pop_front();
          chk("grant_cur_id", 64'(cur_id), 64'(g.id));
          chk("grant_addr",   64'(m_addr), 64'(g.addr));
          chk("grant_wdata",  64'(m_wdata), 64'(g.wdata));
          chk("grant_wen",    64'(m_wen), 64'(g.wen));
        end
      end
      if (mon_mv && !mon_mr) begin
        chk("mvalid_held", 64'(m_valid), 64'(1));
        chk("payload_stable", {m_wen, m_addr, m_wdata}, {hold_wen, hold_addr, hold_wdata});
      end
      if (req_ready != 3'b000) begin
        last_ready_cyc = cyc;
        if (exp_done.size() == 0) fail_now("unexpected_req_ready");
        else begin
          d = exp_done.pop_front();
          chk("ready_onehot", 64'(req_ready), 64'(3'(1) << d.id));
          chk("ready_cur_id", 64'(cur_id), 64'(d.id));
          if (d.is_rd) begin
            chk("rd_data", 64'(req_rdata), 64'(d.rdata));
            chk("rd_ready_timing", 64'(cyc), 64'(last_rdv_cyc + 1));
          end
        end
      end
    end
    mon_mv = m_valid;
    mon_mr = m_ready;
  end

  task automatic set_payload(input int p, input logic [23:0] a, input logic [31:0] w, input logic [3:0] s);
    req_addr[p*24 +: 24]  = a;
    req_wdata[p*32 +: 32] = w;
    req_wen[p*4 +: 4]     = s;
  endtask

  task automatic expect_txn(input int p, input logic [23:0] a, input logic [31:0] w, input logic [3:0] s,
                            input logic [31:0] rd);
    exp_grant.push_back('{id: 2'(p), addr: a, wdata: w, wen: s});
    exp_done.push_back('{id: 2'(p), is_rd: (s == 4'h0), rdata: rd});
  endtask

  task automatic wait_grants(input int left, input string what);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (exp_grant.size() <= left) return;
    end
    fail_now({what, "_grant_timeout"});
    exp_grant.delete();
  endtask

  task automatic wait_all(input string what);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (exp_grant.size() == 0 && exp_done.size() == 0) return;
    end
    fail_now({what, "_done_timeout"});
    exp_grant.delete();
    exp_done.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m_valid"},   64'(m_valid), 64'(0));
    chk({tag, "_m_addr"},    64'(m_addr), 64'(0));
    chk({tag, "_m_wdata"},   64'(m_wdata), 64'(0));
    chk({tag, "_m_wen"},     64'(m_wen), 64'(0));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_req_rdata"}, 64'(req_rdata), 64'(0));
    chk({tag, "_cur_id"},    64'(cur_id), 64'(3));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    req_valid = 3'b000;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c0;
    @(posedge clk); #1;
    ctrl_stall = v.stall;
    ctrl_lat   = v.lat;
    ctrl_rdata = v.ret;
    set_payload(v.port, v.addr, v.wdata, v.wen);
    expect_txn(v.port, v.addr, v.wdata, v.wen, v.exp_rdata);
    req_valid = 3'(1) << v.port;
    c0 = cyc;
    wait_all(tag);
    req_valid = 3'b000;
    chk({tag, "_mvalid_latency"}, 64'(last_grant_cyc - c0), 64'(1));
    chk({tag, "_ready_latency"},  64'(last_ready_cyc - c0), 64'(v.exp_lat));
  endtask

  // Fixed per-port write payloads for the arbitration sequences.
  task automatic load_fixed_payloads();
    set_payload(0, 24'h000A00, 32'h0000_00A0, 4'hF);
    set_payload(1, 24'h000B11, 32'h1111_00B1, 4'h3);
    set_payload(2, 24'h000C22, 32'h2222_00C2, 4'hC);
  endtask

  task automatic expect_fixed(input int p);
    case (p)
      0: expect_txn(0, 24'h000A00, 32'h0000_00A0, 4'hF, 32'h0);
      1: expect_txn(1, 24'h000B11, 32'h1111_00B1, 4'h3, 32'h0);
      default: expect_txn(2, 24'h000C22, 32'h2222_00C2, 4'hC, 32'h0);
    endcase
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [6];
  int   rr_order  [6]  = '{1, 2, 1, 2, 1, 2};
  int   hog_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin : stim
    //                port addr         wdata          wen   stall lat ret            exp_rdata      exp_lat
    vecs[0] = '{1, 24'h000100, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0,        32'h0,        2};
    vecs[1] = '{2, 24'h00ABCD, 32'h0,        4'h0, 0, 5, 32'h12345678, 32'h12345678, 7};
    vecs[2] = '{0, 24'h123456, 32'h0,        4'h0, 2, 2, 32'hCAFEF00D, 32'hCAFEF00D, 6};
    vecs[3] = '{0, 24'hFFFFFF, 32'h0BADC0DE, 4'h3, 0, 1, 32'h0,        32'h0,        2};
    vecs[4] = '{1, 24'h000001, 32'h0,        4'h0, 1, 3, 32'hA5A55A5A, 32'hA5A55A5A, 6};
    vecs[5] = '{2, 24'h800000, 32'h76543210, 4'h8, 3, 1, 32'h0,        32'h0,        5};

    rstn = 1'b0; req_valid = 3'b000; req_addr = '0; req_wdata = '0; req_wen = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Round-robin between ports 1 and 2 from a clean reset.
    do_reset();
    load_fixed_payloads();
    ctrl_stall = 0;
    for (int i = 0; i < 6; i++) expect_fixed(rr_order[i]);
    req_valid = 3'b110;
    wait_grants(0, "rr");
    req_valid = 3'b000;
    wait_all("rr");

    // Port 0 saturating against a waiting port 1.
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) expect_fixed(hog_order[i]);
    req_valid = 3'b011;
    wait_grants(0, "hog");
    req_valid = 3'b000;
    wait_all("hog");

    // Backpressure: port 1 stalled in ISSUE while port 0 arrives.
    @(posedge clk); #1;
    ctrl_stall = 10;
    expect_fixed(1);
    expect_fixed(0);
    req_valid = 3'b010;
    wait_grants(1, "bp");
    req_valid[0] = 1'b1;
    ctrl_stall = 0;
    wait_grants(0, "bp");
    req_valid = 3'b000;
    wait_all("bp");

    // Reset in WAIT_RD, then stale read data must be ignored.
    run_vec(vecs[1], "pre_rst_rd");
    @(posedge clk); #1;
    ctrl_lat   = 12;
    ctrl_rdata = 32'h5EED0BAD;
    set_payload(2, 24'h000777, 32'h0, 4'h0);
    exp_grant.push_back('{id: 2'd2, addr: 24'h000777, wdata: 32'h0, wen: 4'h0});
    req_valid = 3'b100;
    wait_grants(0, "midrd");
    begin : wait_accept
      for (int i = 0; i < 50; i++) begin
        @(negedge clk); #1;
        if (!m_valid) disable wait_accept;
      end
      fail_now("midrd_accept_timeout");
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    req_valid = 3'b000;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset_vals("midrd");
    repeat (16) @(negedge clk);
    chk("stale_rdv_rdata", 64'(req_rdata), 64'(0));
    chk("stale_rdv_ready", 64'(req_ready), 64'(0));
    chk("stale_rdv_cur_id", 64'(cur_id), 64'(3));

    run_vec(vecs[2], "post_rst_rd");
    run_vec(vecs[0], "post_rst_wr");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_grant.size() + exp_done.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
